// File: rtl/tff_arb_pkg.sv
// Shared types and helpers for tff_toggle_arbiter.
// Optional lock feature is enabled by defining TFF_ARB_LOCK_EN.
package tff_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  // Index of the set bit in a one-hot vector; 0 when the vector is all-zero.
  function automatic int unsigned onehot_to_idx(input logic [15:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first active request after ptr, wrapping
// modulo NREQ. Used by tff_toggle_arbiter (TFF_ARB_LOCK_EN selects lock mode there).
module rr_pick
  import tff_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] win,
  output logic [IDXW-1:0] win_idx,
  output logic            any
);

  int w_idx;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    win   = '0;
    any   = 1'b0;
    w_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(ptr) + k) % NREQ;
      if (!any && req[w_idx]) begin
        win[w_idx] = 1'b1;
        any        = 1'b1;
      end
    end
  end

  assign win_idx = IDXW'(onehot_to_idx(16'(win)));

endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin shared T-FF bank: the granted requester's mask toggles q.
// Define TFF_ARB_LOCK_EN to enable the lock port and the LOCKED state.
module tff_toggle_arbiter
  import tff_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] mask,
  input  logic [NREQ-1:0]       lock,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_q;
  logic [IDXW-1:0]  r_ptr;

  logic [NREQ-1:0]  w_req_eff;
  logic [NREQ-1:0]  w_win;
  logic [IDXW-1:0]  w_win_idx;
  logic             w_any;
  logic [WIDTH-1:0] w_mask;

`ifdef TFF_ARB_LOCK_EN
  state_t           r_state;
  logic [IDXW-1:0]  r_owner;
  logic             r_busy;
  logic [NREQ-1:0]  w_owner_oh;

  // While locked only the owner may be picked; the picker then returns the owner.
  assign w_owner_oh = NREQ'(1) << r_owner;
  assign w_req_eff  = (r_state == ST_LOCKED) ? (req & w_owner_oh) : req;
  assign busy       = r_busy;
`else
  logic w_unused_lock;

  assign w_unused_lock = ^lock;
  assign w_req_eff     = req;
  assign busy          = 1'b0;
`endif

  rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req     (w_req_eff),
    .ptr     (r_ptr),
    .win     (w_win),
    .win_idx (w_win_idx),
    .any     (w_any)
  );

  assign w_mask = mask[int'(w_win_idx)*WIDTH +: WIDTH];

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt   <= '0;
      r_q     <= '0;
      r_ptr   <= IDXW'(NREQ - 1);
`ifdef TFF_ARB_LOCK_EN
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_busy  <= 1'b0;
`endif
    end else begin
      r_gnt <= w_win;
      if (w_any) begin
        r_q   <= r_q ^ w_mask;
        r_ptr <= w_win_idx;
      end
`ifdef TFF_ARB_LOCK_EN
      case (r_state)
        ST_IDLE: begin
          if (w_any && lock[w_win_idx]) begin
            r_state <= ST_LOCKED;
            r_owner <= w_win_idx;
            r_busy  <= 1'b1;
          end
        end
        ST_LOCKED: begin
          // The releasing edge still services the owner (handled above).
          if (!lock[r_owner]) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
`endif
    end
  end

  assign gnt = r_gnt;
  assign q   = r_q;

endmodule

// File: tb/tb_tff_toggle_arbiter.sv
// Scoreboard bench for tff_toggle_arbiter; LOCKED scenarios run when
// TFF_ARB_LOCK_EN is defined, lock-ignored scenario otherwise.
module tb_tff_toggle_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] q;
    logic             busy;
    string            name;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] mask = '0;
  logic [NREQ-1:0]       lock = '0;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic                  busy;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  tff_toggle_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .mask (mask),
    .lock (lock),
    .gnt  (gnt),
    .q    (q),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle of stimulus and queue the response expected after the next edge.
  task automatic step(input logic r, input logic [NREQ-1:0] rq, input logic [31:0] m,
                      input logic [NREQ-1:0] lk, input logic [NREQ-1:0] eg,
                      input logic [WIDTH-1:0] eq, input logic eb, input string nm);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req  = rq;
    mask = m;
    lock = lk;
    e.gnt = eg; e.q = eq; e.busy = eb; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input string nm);
    step(1'b1, 4'h0, 32'h0, 4'h0, 4'h0, 8'h00, 1'b0, nm);
  endtask

  // Monitor: compare every queued expectation just after the edge it describes.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".gnt"},  32'(gnt),  32'(e.gnt));
        check({e.name, ".q"},    32'(q),    32'(e.q));
        check({e.name, ".busy"}, 32'(busy), 32'(e.busy));
      end
    end
  end

  initial begin
    // Reset dominates a full request vector
    step(1'b1, 4'hF, 32'hFFFF_FFFF, 4'h0, 4'h0, 8'h00, 1'b0, "rst0");
    step(1'b1, 4'hF, 32'hFFFF_FFFF, 4'h0, 4'h0, 8'h00, 1'b0, "rst1");
    step(1'b0, 4'b0001, 32'h0000_000F, 4'h0, 4'b0001, 8'h0F, 1'b0, "first");

    // All four requesting: rotation 0,1,2,3,0
    do_reset("rst_rr");
    step(1'b0, 4'hF, 32'h0804_0201, 4'h0, 4'b0001, 8'h01, 1'b0, "rr0");
    step(1'b0, 4'hF, 32'h0804_0201, 4'h0, 4'b0010, 8'h03, 1'b0, "rr1");
    step(1'b0, 4'hF, 32'h0804_0201, 4'h0, 4'b0100, 8'h07, 1'b0, "rr2");
    step(1'b0, 4'hF, 32'h0804_0201, 4'h0, 4'b1000, 8'h0F, 1'b0, "rr3");
    step(1'b0, 4'hF, 32'h0804_0201, 4'h0, 4'b0001, 8'h0E, 1'b0, "rr4");

    // Single requester re-granted every cycle
    do_reset("rst_solo");
    step(1'b0, 4'b0100, 32'h00FF_0000, 4'h0, 4'b0100, 8'hFF, 1'b0, "solo0");
    step(1'b0, 4'b0100, 32'h00FF_0000, 4'h0, 4'b0100, 8'h00, 1'b0, "solo1");
    step(1'b0, 4'b0100, 32'h00FF_0000, 4'h0, 4'b0100, 8'hFF, 1'b0, "solo2");

    // Idle hold, zero-mask grant, wrap-around from pointer 1
    do_reset("rst_idle");
    step(1'b0, 4'b0001, 32'h0000_003C, 4'h0, 4'b0001, 8'h3C, 1'b0, "load3c");
    for (int i = 0; i < 5; i++)
      step(1'b0, 4'h0, 32'hFFFF_FFFF, 4'h0, 4'h0, 8'h3C, 1'b0, "idle");
    step(1'b0, 4'b0010, 32'h0000_0000, 4'h0, 4'b0010, 8'h3C, 1'b0, "zeromask");
    step(1'b0, 4'b0011, 32'h0000_0201, 4'h0, 4'b0001, 8'h3D, 1'b0, "wrap0");
    step(1'b0, 4'b0011, 32'h0000_0201, 4'h0, 4'b0010, 8'h3F, 1'b0, "wrap1");

`ifdef TFF_ARB_LOCK_EN
    // Requester 1 locks the bank while 0 and 3 wait
    do_reset("rst_lock");
    step(1'b0, 4'b0001, 32'h0000_0000, 4'h0,    4'b0001, 8'h00, 1'b0, "lk_pre");
    step(1'b0, 4'b1011, 32'hBB00_11AA, 4'b0010, 4'b0010, 8'h11, 1'b1, "lk0");
    step(1'b0, 4'b1011, 32'hBB00_11AA, 4'b0010, 4'b0010, 8'h00, 1'b1, "lk1");
    step(1'b0, 4'b1011, 32'hBB00_11AA, 4'b1011, 4'b0010, 8'h11, 1'b1, "lk2");
    step(1'b0, 4'b1011, 32'hBB00_11AA, 4'b0010, 4'b0010, 8'h00, 1'b1, "lk3");
    step(1'b0, 4'b1011, 32'hBB00_11AA, 4'b0000, 4'b0010, 8'h11, 1'b0, "lk_rel");
    step(1'b0, 4'b1011, 32'hBB00_11AA, 4'b0000, 4'b1000, 8'hAA, 1'b0, "lk_next3");
    step(1'b0, 4'b1011, 32'hBB00_11AA, 4'b0000, 4'b0001, 8'h00, 1'b0, "lk_next0");

    // Reset while locked discards ownership
    step(1'b0, 4'b0010, 32'hBB00_11AA, 4'b0010, 4'b0010, 8'h11, 1'b1, "lk_again");
    step(1'b1, 4'b0010, 32'hBB00_11AA, 4'b0010, 4'b0000, 8'h00, 1'b0, "lk_rst");
    step(1'b0, 4'b1000, 32'hBB00_11AA, 4'b0000, 4'b1000, 8'hBB, 1'b0, "post_rst");
`else
    // Lock requests have no effect in the pure round-robin build
    step(1'b0, 4'b0100, 32'h0001_0000, 4'hF, 4'b0100, 8'h3E, 1'b0, "nolock0");
    step(1'b0, 4'b1100, 32'h0001_0000, 4'hF, 4'b1000, 8'h3E, 1'b0, "nolock1");
`endif

    @(negedge clk);
    req  = '0;
    lock = '0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
